// File: rtl/quad_sum_pkg.sv
// ---------------------------------------------------------------------------
// quad_sum_pkg
//
// Definitions shared between the 4-operand adder stage and its downstream
// block accumulator.
//
//   SUM_W       : width of the adder's output sum.
//   acc_state_e : accumulator FSM states.
//   acc_width() : accumulator width needed to add `count` values of `in_w`
//                 bits without overflow.
// ---------------------------------------------------------------------------
package quad_sum_pkg;

    // Output width of the 4 x 8-bit adder stage.
    localparam int unsigned SUM_W = 10;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // The sum of `count` values, each below 2^in_w, is below count * 2^in_w.
    // So in_w + clog2(count) bits always hold it.
    function automatic int unsigned acc_width(int unsigned in_w, int unsigned count);
        return in_w + $clog2(count);
    endfunction

endpackage

// File: rtl/quad_sum_accumulator.sv
// ---------------------------------------------------------------------------
// quad_sum_accumulator
//
// Accumulates COUNT partial sums from the quad adder into one block total.
// Each total is presented on a valid/ready port and held there until the
// consumer takes it.
//
// Parameters:
//   IN_W   : width of the incoming sum (defaults to the adder output width).
//   COUNT  : sums per block, 2..256.
//   ACC_W  : accumulator/output width. It is derived from IN_W and COUNT and
//            must not be overridden.
//
// Ports:
//   clk        : clock, rising edge.
//   rst_n      : asynchronous active-low reset.
//   clear      : synchronous flush of the partial block and of any pending
//                output. A beat presented in the same cycle is dropped.
//   in_valid   : in_sum is valid.
//   in_ready   : this block can accept in_sum this cycle.
//   in_sum     : unsigned partial sum.
//   out_valid  : out_acc holds a completed block total.
//   out_ready  : consumer accepts out_acc.
//   out_acc    : unsigned block total.
//   out_avg    : block total divided by COUNT, rounded half-up. This port is
//                only present when QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN is
//                defined; that build also requires COUNT to be a power of two.
//
// Configuration macro: QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
// ---------------------------------------------------------------------------
module quad_sum_accumulator
    import quad_sum_pkg::*;
#(
    parameter int unsigned IN_W  = SUM_W,
    parameter int unsigned COUNT = 4,
    parameter int unsigned ACC_W = acc_width(IN_W, COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
    ,
    output logic [IN_W-1:0]  out_avg
`endif
);

    localparam int unsigned     CNT_W    = $clog2(COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (COUNT < 2 || COUNT > 256) begin : g_bad_count
        $error("quad_sum_accumulator: COUNT must be in 2..256");
    end

    if (ACC_W != acc_width(IN_W, COUNT)) begin : g_bad_acc_w
        $error("quad_sum_accumulator: ACC_W is derived and must not be overridden");
    end

`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
    if ((COUNT & (COUNT - 1)) != 0) begin : g_bad_pow2
        $error("quad_sum_accumulator: out_avg requires COUNT to be a power of two");
    end
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_acc_q;

    logic             in_fire;
    logic             out_fire;
    logic             load_out;   // capture a finished total into the output register
    logic [ACC_W-1:0] sum_next;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign sum_next = acc_q + ACC_W'(in_sum);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_out = 1'b0;

        if (clear) begin
            // Beat and pending total are both dropped. out_acc keeps its
            // value because load_out stays low.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_fire) begin
                        if (cnt_q == CNT_LAST) begin
                            load_out = 1'b1;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = HOLD;
                        end else begin
                            acc_d = sum_next;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // in_ready follows out_ready here, so an input beat can
                    // only arrive together with the output handshake. That
                    // beat starts the next block without a bubble.
                    if (out_fire) begin
                        state_d = ACCUM;
                        if (in_fire) begin
                            acc_d = ACC_W'(in_sum);
                            cnt_d = CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == HOLD);
        // rst_n gating holds in_ready low for the whole reset. It then goes
        // high as soon as reset is released, without waiting for a clock edge.
        in_ready  = rst_n && ((state_q == ACCUM) || out_ready);
    end

    // -----------------------------------------------------------------------
    // Accumulator, beat counter and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (load_out) begin
                out_acc_q <= sum_next;
            end
        end
    end

    assign out_acc = out_acc_q;

`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
    // -----------------------------------------------------------------------
    // Rounded average. COUNT is a power of two, so the divide is a shift.
    // The COUNT/2 rounding bias cannot overflow ACC_W. The largest biased
    // total is COUNT*(2^IN_W-1) + COUNT/2, which is below COUNT*2^IN_W.
    // -----------------------------------------------------------------------
    localparam int unsigned LOG2_COUNT = $clog2(COUNT);

    logic [ACC_W-1:0] rounded;
    logic [IN_W-1:0]  avg_q;

    assign rounded = sum_next + ACC_W'(COUNT / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q <= '0;
        end else if (load_out) begin
            avg_q <= IN_W'(rounded >> LOG2_COUNT);
        end
    end

    assign out_avg = avg_q;
`endif

endmodule

// File: tb/tb_quad_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_quad_sum_accumulator
//
// Directed bench for quad_sum_accumulator with COUNT = 4. A block-level
// model counts accepted beats and produces the expected totals. A compare
// process checks the DUT against this model on every falling edge. Literal
// checks at key points confirm that the model itself is correct.
// ---------------------------------------------------------------------------
module tb_quad_sum_accumulator;

    localparam int unsigned IN_W  = 10;
    localparam int unsigned COUNT = 4;
    localparam int unsigned ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_acc;
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
    logic [IN_W-1:0]  out_avg;
`endif

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    quad_sum_accumulator #(
        .IN_W  (IN_W),
        .COUNT (COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc)
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
        ,
        .out_avg   (out_avg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Block-level model. It tracks the running total and beat count of the
    // open block, and the last completed total with its pending flag.
    // -----------------------------------------------------------------------
    int unsigned m_sum = 0;
    int unsigned m_n = 0;
    bit          m_valid = 0;
    int unsigned m_acc = 0;
    int unsigned m_avg = 0;
    int unsigned t_sum;
    int unsigned t_n;
    bit          t_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum   <= 0;
            m_n     <= 0;
            m_valid <= 0;
            m_acc   <= 0;
            m_avg   <= 0;
        end else if (clear) begin
            m_sum   <= 0;
            m_n     <= 0;
            m_valid <= 0;
        end else begin
            t_sum   = m_sum;
            t_n     = m_n;
            t_valid = m_valid;
            if (m_valid && out_ready) t_valid = 0;
            // A new beat is taken unless a total is pending and not being drained.
            if (in_valid && (!m_valid || out_ready)) begin
                t_sum = t_sum + in_sum;
                t_n   = t_n + 1;
                if (t_n == COUNT) begin
                    m_acc   <= t_sum;
                    m_avg   <= (t_sum + COUNT / 2) / COUNT;
                    t_valid = 1;
                    t_sum   = 0;
                    t_n     = 0;
                end
            end
            m_sum   <= t_sum;
            m_n     <= t_n;
            m_valid <= t_valid;
        end
    end

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, rst_n && (!m_valid || out_ready));
            chk("out_valid", out_valid, m_valid);
            chk("out_acc", out_acc, m_acc);
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
            chk("out_avg", out_avg, m_avg);
`endif
        end
    end

    // Presents one beat and waits, for a bounded time, until it is accepted.
    task automatic send(input int unsigned v);
        bit r;
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_sum   = IN_W'(v);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0d", v);
        end
    endtask

    // Waits, for a bounded time, for out_valid, then checks literal values.
    task automatic wait_out(input string name, input int unsigned e_acc,
                            input int unsigned e_avg);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk({name, "_valid"}, seen, 1);
        chk({name, "_acc"}, out_acc, e_acc);
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
        chk({name, "_avg"}, out_avg, e_avg);
`else
        if (e_avg == 0) total = total + 0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        #2 rst_n = 1'b1;
        #1 chk("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic block: output appears one cycle after the 4th beat.
        send(10); send(20); send(30); send(40);
        @(negedge clk);
        chk("basic_valid", out_valid, 1);
        chk("basic_acc", out_acc, 100);
`ifdef QUAD_SUM_ACCUMULATOR_AVG_OUTPUT_EN
        chk("basic_avg", out_avg, 25);
`endif
        @(posedge clk);
        #1;

        // Maximum values
        for (int i = 0; i < 4; i++) send(1020);
        wait_out("max", 4080, 1020);

        // Back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(5);
        in_valid = 1'b1;
        in_sum   = 10'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_acc", out_acc, 20);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_sum    = 10'd7;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(1); send(1); send(1);
        wait_out("bp_next", 10, 3);

        // Clear while a total is pending: it is dropped but stays on the bus.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(50);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_hold_valid", out_valid, 0);
        chk("clr_hold_acc", out_acc, 200);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Clear mid-block: the beat presented with clear is discarded.
        send(100); send(200);
        in_valid = 1'b1;
        in_sum   = 10'd300;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send(1); send(2); send(3); send(4);
        wait_out("clr_mid", 10, 3);

        // Reset while HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4);
        @(negedge clk);
        chk("rsth_valid_before", out_valid, 1);
        chk("rsth_acc_before", out_acc, 16);
        #2 rst_n = 1'b0;
        #1;
        chk("rsth_valid", out_valid, 0);
        chk("rsth_acc", out_acc, 0);
        chk("rsth_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rsth_rel_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(9);
        wait_out("post_rst", 36, 9);

        // Rounding
        send(1); send(1); send(1); send(3);
        wait_out("round_up", 6, 2);
        send(1); send(1); send(1); send(2);
        wait_out("round_dn", 5, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
